// File: rtl/inst_seq_if.sv
// Instruction-bus and decode-output bundle for the fetch/decode sequencer.
// master drives the bus words and HOLD; slave is the sequencer.
interface inst_seq_if #(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = 12
);
    logic [DW-1:0] D;
    logic          D_VLD;
    logic          HOLD;
    logic          FETCH;
    logic [DW-1:0] I;
    logic [AW-1:0] TGT;
    logic          EXEC;
    logic          BUSY;
    logic          ARI;
    logic          LOG;
    logic          LD;
    logic          STR;
    logic          SEI;
    logic          SML;
    logic          SMH;
    logic          JMP;
    logic          LDD;
    logic          W_CAR;

    modport master (
        output D, D_VLD, HOLD,
        input  FETCH, I, TGT, EXEC, BUSY,
        input  ARI, LOG, LD, STR, SEI, SML, SMH, JMP, LDD, W_CAR
    );

    modport slave (
        input  D, D_VLD, HOLD,
        output FETCH, I, TGT, EXEC, BUSY,
        output ARI, LOG, LD, STR, SEI, SML, SMH, JMP, LDD, W_CAR
    );
endinterface

// File: rtl/inst_seq.sv
// Instruction fetch/decode sequencer: latches an opcode, gathers AW/DW operand words for
// jump-class opcodes, and holds registered class strobes plus an EXEC qualifier.
module inst_seq #(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = 12
) (
    input logic         CLK,
    input logic         RST,
    inst_seq_if.slave   bus
);

    localparam int unsigned N    = AW / DW;
    localparam int unsigned CntW = (N > 1) ? $clog2(N + 1) : 1;

    if (DW < 4 || AW < DW || (AW % DW) != 0) begin : gen_param_check
        $error("inst_seq: requires DW>=4, AW>=DW and AW a multiple of DW");
    end

    typedef enum logic [1:0] {StOpc, StArg, StExe} state_t;

    typedef struct packed {
        logic ari;
        logic logOp;
        logic ld;
        logic str;
        logic sei;
        logic sml;
        logic smh;
        logic jmp;
        logic ldd;
        logic wCar;
    } cls_t;

    state_t          stateQ, stateD;
    logic [DW-1:0]   iQ, iD;
    logic [AW-1:0]   tgtQ, tgtD;
    logic [CntW-1:0] cntQ, cntD;
    cls_t            clsQ, clsD;

    logic [3:0] op;
    logic       capture;
    logic       shiftIn;
    logic       lastArg;

    function automatic cls_t decode(input logic [3:0] opc);
        cls_t c;
        c = '0;
        unique case (opc)
            4'h0:                      begin c.ld = 1'b1; c.logOp = 1'b1; end
            4'h1:                      c.str = 1'b1;
            4'h2:                      c.sei = 1'b1;
            4'h3:                      c.sml = 1'b1;
            4'h4, 4'h5, 4'h6:          c.jmp = 1'b1;
            4'h7:                      c.ldd = 1'b1;
            4'h8, 4'h9:                c.ari = 1'b1;
            4'hA, 4'hB:                begin c.ari = 1'b1; c.wCar = 1'b1; end
            4'hC, 4'hD, 4'hE:          c.logOp = 1'b1;
            4'hF:                      c.smh = 1'b1;
            default:                   c = '0;
        endcase
        return c;
    endfunction

    assign op      = bus.D[DW-1:DW-4];
    assign capture = (stateQ == StOpc) && bus.D_VLD;
    assign shiftIn = (stateQ == StArg) && bus.D_VLD;
    assign lastArg = (cntQ == CntW'(N - 1));

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stateQ <= StOpc;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StOpc: if (bus.D_VLD) stateD = (op[3:2] == 2'b01) ? StArg : StExe;
            StArg: if (bus.D_VLD && lastArg) stateD = StExe;
            StExe: if (!bus.HOLD) stateD = StOpc;
            default: stateD = StOpc;
        endcase
    end

    // Outputs depend on state only; RST masks FETCH while reset is held.
    always_comb begin
        bus.FETCH = !RST && (stateQ != StExe);
        bus.EXEC  = (stateQ == StExe);
        bus.BUSY  = (stateQ == StArg);
    end

    always_comb begin
        iD   = iQ;
        tgtD = tgtQ;
        cntD = cntQ;
        clsD = clsQ;
        if (capture) begin
            iD   = bus.D;
            tgtD = '0;
            cntD = '0;
            clsD = decode(op);
        end else if (shiftIn) begin
            // Shift-in form also covers AW==DW, where the whole target is the new word.
            tgtD = (tgtQ << DW) | AW'(bus.D);
            cntD = cntQ + CntW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            iQ   <= '0;
            tgtQ <= '0;
            cntQ <= '0;
            clsQ <= '0;
        end else begin
            iQ   <= iD;
            tgtQ <= tgtD;
            cntQ <= cntD;
            clsQ <= clsD;
        end
    end

    assign bus.I     = iQ;
    assign bus.TGT   = tgtQ;
    assign bus.ARI   = clsQ.ari;
    assign bus.LOG   = clsQ.logOp;
    assign bus.LD    = clsQ.ld;
    assign bus.STR   = clsQ.str;
    assign bus.SEI   = clsQ.sei;
    assign bus.SML   = clsQ.sml;
    assign bus.SMH   = clsQ.smh;
    assign bus.JMP   = clsQ.jmp;
    assign bus.LDD   = clsQ.ldd;
    assign bus.W_CAR = clsQ.wCar;

endmodule

// File: tb/tb_inst_seq.sv
// Directed bench for inst_seq: drives 1 ns after each rising edge and checks there.
module tb_inst_seq;

    localparam int unsigned DW = 4;
    localparam int unsigned AW = 12;

    logic CLK = 1'b0;
    logic RST;

    int nTests = 0;
    int nFail  = 0;
    int execCnt;

    inst_seq_if #(.DW(DW), .AW(AW)) bus ();

    inst_seq #(.DW(DW), .AW(AW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST        = 1'b1;
        bus.D      = '0;
        bus.D_VLD  = 1'b0;
        bus.HOLD   = 1'b0;

        // Reset state
        tick();
        tick();
        checkVal("rst_fetch", 32'(bus.FETCH), 32'd0);
        checkVal("rst_exec",  32'(bus.EXEC),  32'd0);
        checkVal("rst_i",     32'(bus.I),     32'd0);
        checkVal("rst_tgt",   32'(bus.TGT),   32'd0);
        RST = 1'b0;
        #1;
        checkVal("rel_fetch", 32'(bus.FETCH), 32'd1);
        checkVal("rel_busy",  32'(bus.BUSY),  32'd0);

        // ARI without carry, then with carry
        bus.D = 4'h9; bus.D_VLD = 1'b1;
        tick();
        bus.D_VLD = 1'b0;
        checkVal("ari9_i",     32'(bus.I),     32'h9);
        checkVal("ari9_ari",   32'(bus.ARI),   32'd1);
        checkVal("ari9_wcar",  32'(bus.W_CAR), 32'd0);
        checkVal("ari9_exec",  32'(bus.EXEC),  32'd1);
        checkVal("ari9_fetch", 32'(bus.FETCH), 32'd0);
        tick();
        checkVal("ari9_exec_end", 32'(bus.EXEC), 32'd0);
        checkVal("ari9_hold_ari", 32'(bus.ARI),  32'd1);
        bus.D = 4'hA; bus.D_VLD = 1'b1;
        tick();
        bus.D_VLD = 1'b0;
        checkVal("ariA_ari",  32'(bus.ARI),   32'd1);
        checkVal("ariA_wcar", 32'(bus.W_CAR), 32'd1);
        checkVal("ariA_exec", 32'(bus.EXEC),  32'd1);
        tick();
        checkVal("ariA_exec_end", 32'(bus.EXEC), 32'd0);

        // JMP with gaps between operand words
        bus.D = 4'h5; bus.D_VLD = 1'b1;
        tick();
        bus.D_VLD = 1'b0;
        checkVal("jmp_busy0", 32'(bus.BUSY), 32'd1);
        checkVal("jmp_jmp",   32'(bus.JMP),  32'd1);
        checkVal("jmp_ari",   32'(bus.ARI),  32'd0);
        checkVal("jmp_tgt0",  32'(bus.TGT),  32'h0);
        checkVal("jmp_exec0", 32'(bus.EXEC), 32'd0);
        tick();
        checkVal("jmp_gap_busy", 32'(bus.BUSY), 32'd1);
        bus.D = 4'h1; bus.D_VLD = 1'b1;
        tick();
        bus.D_VLD = 1'b0;
        checkVal("jmp_tgt1", 32'(bus.TGT), 32'h1);
        tick();
        checkVal("jmp_gap2_busy", 32'(bus.BUSY), 32'd1);
        checkVal("jmp_gap2_exec", 32'(bus.EXEC), 32'd0);
        bus.D = 4'h2; bus.D_VLD = 1'b1;
        tick();
        bus.D_VLD = 1'b0;
        checkVal("jmp_tgt2", 32'(bus.TGT),  32'h12);
        checkVal("jmp_busy2", 32'(bus.BUSY), 32'd1);
        tick();
        bus.D = 4'h3; bus.D_VLD = 1'b1;
        tick();
        bus.D_VLD = 1'b0;
        checkVal("jmp_tgt3",  32'(bus.TGT),  32'h123);
        checkVal("jmp_exec",  32'(bus.EXEC), 32'd1);
        checkVal("jmp_busy3", 32'(bus.BUSY), 32'd0);
        checkVal("jmp_i",     32'(bus.I),    32'h5);
        tick();
        checkVal("jmp_exec_end", 32'(bus.EXEC), 32'd0);
        checkVal("jmp_tgt_keep", 32'(bus.TGT),  32'h123);

        // SMH with HOLD stall; a word offered during the stall must be ignored
        bus.D = 4'hF; bus.D_VLD = 1'b1; bus.HOLD = 1'b1;
        execCnt = 0;
        tick();
        bus.D_VLD = 1'b0;
        checkVal("smh_smh",   32'(bus.SMH),   32'd1);
        checkVal("smh_fetch", 32'(bus.FETCH), 32'd0);
        if (bus.EXEC) execCnt++;
        tick();
        bus.D = 4'h1; bus.D_VLD = 1'b1;
        if (bus.EXEC) execCnt++;
        tick();
        bus.D_VLD = 1'b0;
        if (bus.EXEC) execCnt++;
        tick();
        bus.HOLD = 1'b0;
        if (bus.EXEC) execCnt++;
        checkVal("smh_fetch_stall", 32'(bus.FETCH), 32'd0);
        tick();
        if (bus.EXEC) execCnt++;
        checkVal("smh_exec_cycles", 32'(execCnt),   32'd4);
        checkVal("smh_i_kept",      32'(bus.I),     32'hF);
        checkVal("smh_fetch_back",  32'(bus.FETCH), 32'd1);

        // Reset in the middle of LDD operand collection
        bus.D = 4'h7; bus.D_VLD = 1'b1;
        tick();
        bus.D = 4'hA;
        tick();
        bus.D_VLD = 1'b0;
        checkVal("ldd_tgt_part", 32'(bus.TGT),  32'hA);
        checkVal("ldd_ldd",      32'(bus.LDD),  32'd1);
        checkVal("ldd_busy",     32'(bus.BUSY), 32'd1);
        #2 RST = 1'b1;
        #1;
        checkVal("mid_rst_tgt",  32'(bus.TGT),  32'h0);
        checkVal("mid_rst_ldd",  32'(bus.LDD),  32'd0);
        checkVal("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        checkVal("mid_rst_i",    32'(bus.I),    32'h0);
        tick();
        RST = 1'b0;
        #1;
        checkVal("mid_rel_fetch", 32'(bus.FETCH), 32'd1);
        bus.D = 4'h0; bus.D_VLD = 1'b1;
        tick();
        bus.D_VLD = 1'b0;
        checkVal("ld_ld",   32'(bus.LD),   32'd1);
        checkVal("ld_log",  32'(bus.LOG),  32'd1);
        checkVal("ld_exec", 32'(bus.EXEC), 32'd1);
        checkVal("ld_busy", 32'(bus.BUSY), 32'd0);
        tick();

        // Back-to-back with D_VLD held high
        bus.D = 4'h1; bus.D_VLD = 1'b1;
        tick();
        checkVal("b2b_str",   32'(bus.STR),  32'd1);
        checkVal("b2b_exec1", 32'(bus.EXEC), 32'd1);
        bus.D = 4'h2;
        tick();
        checkVal("b2b_gap1", 32'(bus.EXEC), 32'd0);
        checkVal("b2b_i1",   32'(bus.I),    32'h1);
        tick();
        checkVal("b2b_sei",   32'(bus.SEI),  32'd1);
        checkVal("b2b_str0",  32'(bus.STR),  32'd0);
        checkVal("b2b_exec2", 32'(bus.EXEC), 32'd1);
        bus.D = 4'h3;
        tick();
        checkVal("b2b_gap2", 32'(bus.EXEC), 32'd0);
        tick();
        checkVal("b2b_sml",   32'(bus.SML),  32'd1);
        checkVal("b2b_i3",    32'(bus.I),    32'h3);
        checkVal("b2b_exec3", 32'(bus.EXEC), 32'd1);
        bus.D_VLD = 1'b0;
        tick();
        checkVal("b2b_end", 32'(bus.EXEC), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/inst_seq.md
Name: inst_seq

Overview:
Parametrised instruction fetch/decode sequencer for the 4-bit CPU core. It supersedes the single-word latch-and-decode stage.
- Captures an opcode word from the instruction bus.
- For jump-class opcodes (JMP, LDD), collects AW/DW operand words into a target address.
- Presents registered class strobes and a one-cycle-or-held EXEC qualifier to the datapath.
- Stalls on HOLD from the execute side.

Parameters:
DW, 4, instruction/data word width; class decode uses I[DW-1:DW-4]; DW>=4.
AW, 12, jump/load target width; AW%DW==0 and AW>=DW; operand count N=AW/DW (default 3).

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  reset, asynchronous and active-high.
D  in  DW  instruction bus word.
D_VLD  in  1  D carries a valid word this cycle.
HOLD  in  1  execute stage not ready; holds sequencer in EXE.
FETCH  out  1  sequencer accepts a word this cycle when D_VLD=1.
I  out  DW  latched opcode word.
TGT  out  AW  assembled operand address, first word most significant.
EXEC  out  1  decoded instruction (and TGT) valid for execution.
BUSY  out  1  high in ARG state.
ARI, LOG, LD, STR, SEI, SML, SMH, JMP, LDD, W_CAR  out  1 each  registered class strobes.

Behaviour:
Decode is on op=I[DW-1:DW-4]:
- LD=0x0, STR=0x1, SEI=0x2, SML=0x3.
- JMP=0x4..0x6, LDD=0x7.
- ARI=0x8..0xB; W_CAR=0xA,0xB (also raises ARI).
- LOG=0x0,0xC,0xD,0xE (0x0 raises LD and LOG together).
- SMH=0xF.

Reset (async, RST=1): state=OPC; I=0, TGT=0, all class strobes=0, EXEC=0, BUSY=0, FETCH=1 once RST deasserts.

FSM states OPC, ARG, EXE:
- OPC: FETCH=1.
  - D_VLD=1 -> I<=D, TGT<=0, class strobes <= decode(D) on the same edge, count<=0.
  - Next state ARG if op in 0x4..0x7, else EXE.
  - D_VLD=0 -> stay; outputs unchanged.
- ARG: FETCH=1, BUSY=1.
  - D_VLD=1 -> TGT<={TGT[AW-DW-1:0],D}, count++.
  - On the Nth accepted word go to EXE.
  - D_VLD=0 -> wait; no count change.
- EXE: EXEC=1, FETCH=0, D and D_VLD ignored.
  - HOLD=1 -> stay with EXEC high and all outputs stable.
  - HOLD=0 -> OPC next cycle.

Timing and stability:
- Class strobes, I and TGT hold their values from capture until the next opcode capture. They do not clear on leaving EXE.
- Latency: a single-word opcode accepted at edge k gives EXEC=1 in cycle k..k+1. Peak throughput is one instruction per 2 cycles.
- Multi-word: EXEC asserts the cycle after the Nth operand is accepted.
- When AW==DW, N=1.
- The operand counter is ceil(log2(N+1)) bits. Count never exceeds N.
- Reset mid-ARG or mid-EXE aborts immediately to OPC with all reset values. A partial TGT is discarded.
- RST has priority over D_VLD and HOLD on the same edge.
- FETCH and EXEC are combinational from state only, never from D_VLD or HOLD.

Test Plan:
- Reset check: assert RST mid-cycle with no clock edge -> all outputs 0 immediately. Release RST -> FETCH=1, EXEC=0.
- ARI and W_CAR decode: D=0x9, D_VLD=1 for one cycle -> next cycle I=0x9, ARI=1, W_CAR=0, EXEC=1 for exactly 1 cycle. Then repeat with D=0xA -> ARI=1, W_CAR=1.
- Jump with operand gaps: D=0x5, then operands 0x1, 0x2, 0x3 with D_VLD low one cycle between each -> BUSY high throughout ARG, JMP=1, TGT=0x123, EXEC rises the cycle after 0x3 is accepted.
- HOLD stall: D=0xF with HOLD=1 for 3 cycles in EXE -> SMH=1, EXEC high 4 cycles, FETCH=0. A D_VLD pulse with D=0x1 during the stall is ignored (I stays 0xF).
- Reset mid-ARG: D=0x7, operand 0xA, then RST -> TGT=0, LDD=0, state OPC. Next D=0x0 -> LD=1 and LOG=1, EXEC next cycle.
- Back-to-back: D_VLD held 1 with D=0x1,0x2,0x3... -> an instruction is accepted every other cycle, STR, SEI, SML in order, never two EXEC cycles adjacent without HOLD.
